// File: rtl/mem_access_controller_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_controller_pkg
//   Shared widths and FSM encoding for the CPU-side memory initiator. The
//   memory module and the control unit import this package so that all three
//   blocks use the same address/data widths and state codes.
// ---------------------------------------------------------------------------
package mem_access_controller_pkg;

    localparam int MAC_ADDR_W = 10;
    localparam int MAC_DATA_W = 20;

    // Binary-encoded controller state; IDLE is the only non-busy state.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2,
        ST_STORE = 2'd3
    } state_e;

    function automatic logic state_busy(input state_e s);
        return (s != ST_IDLE);
    endfunction

endpackage

// File: rtl/mem_access_controller_if.sv
// ---------------------------------------------------------------------------
// mem_access_controller_if
//   Bundles the core-side request/done handshake and the memory-side bus of
//   the memory access controller.
//
//   Handshake: a request (fetch_req or ls_req) is taken only on a rising edge
//   where busy is low; the core holds it until that happens. Completion is a
//   one-cycle pulse: ir_valid for a fetch, ls_done for a load or store. With
//   both requests high in IDLE, ls_req wins and fetch_req stays pending.
//
//   master : controller view (drives busy/results/memory bus, plus dbg_state)
//   slave  : environment view (core + memory)
// ---------------------------------------------------------------------------
interface mem_access_controller_if
    import mem_access_controller_pkg::*;
#(
    parameter int ADDR_W = MAC_ADDR_W,
    parameter int DATA_W = MAC_DATA_W
) ();

    // core side
    logic              fetch_req;
    logic              fetch_jump;
    logic [ADDR_W-1:0] fetch_pc;
    logic              ls_req;
    logic              ls_write;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              busy;
    logic [DATA_W-1:0] ir;
    logic              ir_valid;
    logic [ADDR_W-1:0] pc_out;
    logic [DATA_W-1:0] ls_rdata;
    logic              ls_done;

    // memory side
    logic [ADDR_W-1:0] mem_pc;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_write;
    logic              mem_wr_select;
    logic [DATA_W-1:0] mem_inst;
    logic [DATA_W-1:0] mem_read;

    // FSM state, exported for observation
    state_e            dbg_state;

    modport master (
        input  fetch_req, fetch_jump, fetch_pc,
        input  ls_req, ls_write, ls_addr, ls_wdata,
        input  mem_inst, mem_read,
        output busy, ir, ir_valid, pc_out, ls_rdata, ls_done,
        output mem_pc, mem_addr, mem_write, mem_wr_select,
        output dbg_state
    );

    modport slave (
        output fetch_req, fetch_jump, fetch_pc,
        output ls_req, ls_write, ls_addr, ls_wdata,
        output mem_inst, mem_read,
        input  busy, ir, ir_valid, pc_out, ls_rdata, ls_done,
        input  mem_pc, mem_addr, mem_write, mem_wr_select,
        input  dbg_state
    );

endinterface

// File: rtl/mem_access_controller_pc_counter.sv
// ---------------------------------------------------------------------------
// pc_counter
//   Program counter register. Load has priority over increment; increment
//   wraps modulo 2^ADDR_W.
//
//   clk        : system clock
//   rst_n      : synchronous active-low reset to RESET_PC
//   load_i     : load load_val_i on the next edge
//   load_val_i : jump target
//   inc_i      : advance by one on the next edge
//   pc_o       : current PC
// ---------------------------------------------------------------------------
module pc_counter #(
    parameter int                ADDR_W   = 10,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/mem_access_controller.sv
// ---------------------------------------------------------------------------
// mem_access_controller
//   CPU-side initiator for the memory module. Sequences instruction fetch,
//   load and store as single-outstanding, one-cycle transactions and keeps
//   the fetched instruction / load result in registers for the control unit.
//   Owns the program counter (pc_counter sub-module).
//
//   clk   : system clock, all state updates on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : core handshake + memory bus (mem_access_controller_if.master)
// ---------------------------------------------------------------------------
module mem_access_controller
    import mem_access_controller_pkg::*;
#(
    parameter int                ADDR_W   = MAC_ADDR_W,
    parameter int                DATA_W   = MAC_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mem_access_controller_if.master bus
);

    state_e            state_q;
    state_e            state_d;

    logic [DATA_W-1:0] ir_q,       ir_d;
    logic              ir_valid_q, ir_valid_d;
    logic [ADDR_W-1:0] pc_out_q,   pc_out_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
    logic              ls_done_q,  ls_done_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdat_q, mem_wdat_d;

    logic              idle;
    logic              accept_ls;
    logic              accept_fetch;
    logic              pc_load;
    logic              pc_inc;
    logic [ADDR_W-1:0] pc;

    // Request arbitration: data access beats fetch so the instruction in
    // flight finishes its load/store before the next one is fetched.
    assign idle         = (state_q == ST_IDLE);
    assign accept_ls    = idle && bus.ls_req;
    assign accept_fetch = idle && !bus.ls_req && bus.fetch_req;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept_ls) begin
                    state_d = bus.ls_write ? ST_STORE : ST_LOAD;
                end else if (accept_fetch) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_IDLE;
            ST_LOAD:  state_d = ST_IDLE;
            ST_STORE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.busy          = state_busy(state_q);
        // Gated by rst_n so an edge that samples reset never commits a store.
        bus.mem_wr_select = (state_q == ST_STORE) && rst_n;
        pc_load           = accept_fetch && bus.fetch_jump;
        pc_inc            = (state_q == ST_FETCH);
    end

    assign bus.dbg_state = state_q;

    // ---------------- program counter ----------------
    pc_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (pc_load),
        .load_val_i (bus.fetch_pc),
        .inc_i      (pc_inc),
        .pc_o       (pc)
    );

    // ---------------- result / bus registers ----------------
    always_comb begin
        ir_d       = ir_q;
        pc_out_d   = pc_out_q;
        ls_rdata_d = ls_rdata_q;
        mem_addr_d = mem_addr_q;
        mem_wdat_d = mem_wdat_q;
        ir_valid_d = (state_q == ST_FETCH);
        ls_done_d  = (state_q == ST_LOAD) || (state_q == ST_STORE);

        // The memory sees mem_pc on the mid-cycle falling edge, so mem_inst
        // is settled by the edge that closes FETCH.
        if (state_q == ST_FETCH) begin
            ir_d     = bus.mem_inst;
            pc_out_d = pc;
        end
        if (state_q == ST_LOAD) begin
            ls_rdata_d = bus.mem_read;
        end
        // Address and write data are captured at acceptance and then held,
        // so the memory sees stable values for the whole access cycle.
        if (accept_ls) begin
            mem_addr_d = bus.ls_addr;
            mem_wdat_d = bus.ls_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            pc_out_q   <= RESET_PC;
            ls_rdata_q <= '0;
            ls_done_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_wdat_q <= '0;
        end else begin
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            pc_out_q   <= pc_out_d;
            ls_rdata_q <= ls_rdata_d;
            ls_done_q  <= ls_done_d;
            mem_addr_q <= mem_addr_d;
            mem_wdat_q <= mem_wdat_d;
        end
    end

    assign bus.ir        = ir_q;
    assign bus.ir_valid  = ir_valid_q;
    assign bus.pc_out    = pc_out_q;
    assign bus.ls_rdata  = ls_rdata_q;
    assign bus.ls_done   = ls_done_q;
    assign bus.mem_pc    = pc;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_write = mem_wdat_q;

endmodule

// File: tb/tb_mem_access_controller.sv
// ---------------------------------------------------------------------------
// tb_mem_access_controller
//   Bench for mem_access_controller: acts as both the core and the memory.
//   Table-driven directed transactions, hand-written corner sequences and a
//   random back-to-back run, with a scoreboard queue of expected results.
// ---------------------------------------------------------------------------
module tb_mem_access_controller;
    import mem_access_controller_pkg::*;

    localparam int AW = 10;
    localparam int DW = 20;

    logic clk;
    logic rst_n;

    mem_access_controller_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_access_controller #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .RESET_PC ('0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- memory model (environment) ----------------
    logic [DW-1:0] imem [0:(1<<AW)-1];
    logic [DW-1:0] dmem [0:(1<<AW)-1];

    assign bus.mem_inst = imem[bus.mem_pc];
    assign bus.mem_read = dmem[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_wr_select) begin
            dmem[bus.mem_addr] <= bus.mem_write;
        end
    end

    // ---------------- reference state ----------------
    logic [DW-1:0] ref_dmem [0:(1<<AW)-1];
    logic [AW-1:0] model_pc;
    logic [DW-1:0] last_rdata;

    // Scoreboard entry: {kind(2), pc(AW), data(DW)}; kind 1 = fetch, 2 = load/store
    logic [31:0] exp_q [$];

    int n_cmp;
    int n_fail;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [31:0] got;
        logic [31:0] exp;
        if (bus.ir_valid || bus.ls_done) begin
            check("pulse_exclusive", {31'd0, bus.ir_valid & bus.ls_done}, 32'd0);
            got = bus.ir_valid ? {2'd1, bus.pc_out, bus.ir} : {2'd2, 10'd0, bus.ls_rdata};
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_unexpected: got %h expected no completion (t=%0t)", got, $time);
            end else begin
                exp = exp_q.pop_front();
                check("sb_result", got, exp);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic idle_inputs();
        bus.fetch_req  = 1'b0;
        bus.fetch_jump = 1'b0;
        bus.fetch_pc   = '0;
        bus.ls_req     = 1'b0;
        bus.ls_write   = 1'b0;
        bus.ls_addr    = '0;
        bus.ls_wdata   = '0;
    endtask

    // Updates the reference model and pushes the expected completion.
    task automatic predict(input logic is_ls, input logic wr, input logic jmp,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        if (is_ls) begin
            if (wr) ref_dmem[addr] = wd;
            else    last_rdata     = ref_dmem[addr];
            exp_q.push_back({2'd2, 10'd0, last_rdata});
        end else begin
            if (jmp) model_pc = addr;
            exp_q.push_back({2'd1, model_pc, imem[model_pc]});
            model_pc = model_pc + AW'(1);
        end
    endtask

    // Issues one transaction starting at a negedge with busy low; returns at
    // the negedge where the completion pulse must be visible.
    task automatic run_txn(input logic is_ls, input logic wr, input logic jmp,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           output logic [DW-1:0] got_data, output logic [AW-1:0] got_pc);
        check("idle_before", {31'd0, bus.busy}, 32'd0);
        predict(is_ls, wr, jmp, addr, wd);
        if (is_ls) begin
            bus.ls_req   = 1'b1;
            bus.ls_write = wr;
            bus.ls_addr  = addr;
            bus.ls_wdata = wd;
        end else begin
            bus.fetch_req  = 1'b1;
            bus.fetch_jump = jmp;
            bus.fetch_pc   = addr;
        end
        @(posedge clk);
        #1;
        idle_inputs();
        check("busy_in_access", {31'd0, bus.busy}, 32'd1);
        check("wr_select_in_access", {31'd0, bus.mem_wr_select}, {31'd0, is_ls & wr});
        @(posedge clk);
        @(negedge clk);
        check("busy_after", {31'd0, bus.busy}, 32'd0);
        check("wr_select_after", {31'd0, bus.mem_wr_select}, 32'd0);
        if (is_ls) check("ls_done_pulse", {31'd0, bus.ls_done}, 32'd1);
        else       check("ir_valid_pulse", {31'd0, bus.ir_valid}, 32'd1);
        check("mem_pc_tracks", {22'd0, bus.mem_pc}, {22'd0, model_pc});
        got_data = is_ls ? bus.ls_rdata : bus.ir;
        got_pc   = bus.pc_out;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n      = 1'b1;
        model_pc   = '0;
        last_rdata = '0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"},     {31'd0, bus.busy},          32'd0);
        check({tag, "_ir"},       {12'd0, bus.ir},            32'd0);
        check({tag, "_ir_valid"}, {31'd0, bus.ir_valid},      32'd0);
        check({tag, "_ls_done"},  {31'd0, bus.ls_done},       32'd0);
        check({tag, "_ls_rdata"}, {12'd0, bus.ls_rdata},      32'd0);
        check({tag, "_pc_out"},   {22'd0, bus.pc_out},        32'd0);
        check({tag, "_mem_pc"},   {22'd0, bus.mem_pc},        32'd0);
        check({tag, "_mem_addr"}, {22'd0, bus.mem_addr},      32'd0);
        check({tag, "_mem_wr"},   {12'd0, bus.mem_write},     32'd0);
        check({tag, "_wr_sel"},   {31'd0, bus.mem_wr_select}, 32'd0);
        check({tag, "_state"},    {30'd0, bus.dbg_state},     {30'd0, ST_IDLE});
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic          is_ls;
        logic          wr;
        logic          jmp;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_data;
        logic [AW-1:0] exp_pc;
    } vec_t;

    vec_t tbl [10];

    initial begin
        logic [DW-1:0] gd;
        logic [AW-1:0] gp;
        n_cmp  = 0;
        n_fail = 0;

        for (int i = 0; i < (1 << AW); i++) begin
            imem[i]     = {AW'(i), ~AW'(i)};
            dmem[i]     = {~AW'(i), AW'(i)};
            ref_dmem[i] = {~AW'(i), AW'(i)};
        end
        imem[0]     = 20'hABCDE;
        imem[1]     = 20'h2468A;
        imem[2]     = 20'hFEDCB;
        imem[1023]  = 20'h13579;
        dmem[0]     = 20'h0F0F0;
        ref_dmem[0] = 20'h0F0F0;

        //             is_ls wr  jmp addr      wdata       exp_data    exp_pc
        tbl[0] = '{1'b0, 1'b0, 1'b0, 10'd0,    20'h00000, 20'hABCDE, 10'd0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 10'd1023, 20'h00000, 20'h13579, 10'd1023};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 10'd0,    20'h00000, 20'hABCDE, 10'd0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 10'd5,    20'h12345, 20'h00000, 10'd0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 10'd5,    20'h00000, 20'h12345, 10'd0};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 10'd1,    20'h00000, 20'h2468A, 10'd1};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 10'd0,    20'h00000, 20'hFEDCB, 10'd2};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 10'd1023, 20'hFFFFF, 20'h12345, 10'd0};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 10'd1023, 20'h00000, 20'hFFFFF, 10'd0};
        tbl[9] = '{1'b1, 1'b0, 1'b0, 10'd0,    20'h00000, 20'h0F0F0, 10'd0};

        idle_inputs();
        apply_reset();
        check_reset_values("reset");

        for (int i = 0; i < 10; i++) begin
            run_txn(tbl[i].is_ls, tbl[i].wr, tbl[i].jmp, tbl[i].addr, tbl[i].wdata, gd, gp);
            check($sformatf("vec%0d_data", i), {12'd0, gd}, {12'd0, tbl[i].exp_data});
            if (!tbl[i].is_ls) check($sformatf("vec%0d_pc", i), {22'd0, gp}, {22'd0, tbl[i].exp_pc});
        end
        check("mem_store5", {12'd0, dmem[5]}, 32'h00012345);

        // ---- fetch and load together: load first, fetch when busy drops;
        //      a store raised during the busy cycle is ignored
        predict(1'b1, 1'b0, 1'b0, 10'd5, 20'h0);
        predict(1'b0, 1'b0, 1'b0, 10'd0, 20'h0);
        bus.fetch_req = 1'b1;
        bus.ls_req    = 1'b1;
        bus.ls_write  = 1'b0;
        bus.ls_addr   = 10'd5;
        @(posedge clk);
        #1;
        check("arb_state_load", {30'd0, bus.dbg_state}, {30'd0, ST_LOAD});
        bus.ls_write = 1'b1;
        bus.ls_addr  = 10'd7;
        bus.ls_wdata = 20'h77777;
        @(posedge clk);
        #1;
        bus.ls_req   = 1'b0;
        bus.ls_write = 1'b0;
        check("arb_idle_after_load", {30'd0, bus.dbg_state}, {30'd0, ST_IDLE});
        @(negedge clk);
        check("arb_ls_done", {31'd0, bus.ls_done}, 32'd1);
        check("arb_rdata", {12'd0, bus.ls_rdata}, 32'h00012345);
        check("arb_mem_addr_held", {22'd0, bus.mem_addr}, 32'd5);
        @(posedge clk);
        #1;
        bus.fetch_req = 1'b0;
        check("arb_state_fetch", {30'd0, bus.dbg_state}, {30'd0, ST_FETCH});
        @(posedge clk);
        @(negedge clk);
        check("arb_ir_valid", {31'd0, bus.ir_valid}, 32'd1);
        check("arb_pc_out", {22'd0, bus.pc_out}, 32'd3);
        check("arb_ignored_store", {12'd0, dmem[7]}, {12'd0, ref_dmem[7]});

        // ---- reset asserted during a STORE cycle
        bus.ls_req   = 1'b1;
        bus.ls_write = 1'b1;
        bus.ls_addr  = 10'd9;
        bus.ls_wdata = 20'hDEAD0;
        @(posedge clk);
        #1;
        idle_inputs();
        check("rst_store_state", {30'd0, bus.dbg_state}, {30'd0, ST_STORE});
        rst_n = 1'b0;
        #1;
        check("rst_store_wr_gated", {31'd0, bus.mem_wr_select}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst_store_word", {12'd0, dmem[9]}, {12'd0, ref_dmem[9]});
        check_reset_values("rst_store");
        rst_n      = 1'b1;
        model_pc   = '0;
        last_rdata = '0;

        // ---- random back-to-back alternating fetch / data access
        for (int i = 0; i < 100; i++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] w;
            a = AW'($urandom_range(0, 15));
            w = DW'($urandom_range(0, (1 << DW) - 1));
            if (i % 2 == 0) begin
                if ($urandom_range(0, 3) == 0) a = AW'($urandom_range(0, (1 << AW) - 1));
                run_txn(1'b0, 1'b0, ($urandom_range(0, 3) == 0), a, w, gd, gp);
            end else begin
                run_txn(1'b1, ($urandom_range(0, 1) == 1), 1'b0, a, w, gd, gp);
            end
        end
        for (int i = 0; i < 16; i++) begin
            check($sformatf("final_dmem%0d", i), {12'd0, dmem[i]}, {12'd0, ref_dmem[i]});
        end

        repeat (3) @(negedge clk);
        check("sb_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
